// File: rtl/lc2k_exec_stage.sv
// lc2k_exec_stage
//   Execute stage for an LC2K pipeline, sitting just behind the register file.
//   Computes the ALU result, memory address and branch decision for one decoded
//   instruction and holds them in a single result register with a valid/ready
//   handshake on both sides. A retired halt parks the stage until reset.
//
//   Ports
//     clk, rst_n              clock (rising edge), async active-low reset
//     in_valid / in_ready     upstream handshake (decoded instruction + operands)
//     in_opcode .. in_valB    decoded fields and register-file read values
//     out_valid / out_ready   downstream handshake for the result register
//     wb_en, wb_reg, wb_value register write-back request
//     mem_rd, mem_wr,
//     mem_addr, mem_wdata     memory access request (lw / sw)
//     br_taken, br_target     PC redirect (beq / jalr)
//     halted                  halt has retired; stage is frozen
//     instr_count             retired instruction count (wraps at 2^32)
//     ovf                     signed overflow of add / address add
//                             (present only with LC2K_EXEC_OVF_EN defined)
//
//   Build option: define LC2K_EXEC_OVF_EN to add the ovf output.
module lc2k_exec_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 3,
  parameter int OFF_W  = 16,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [REG_AW-1:0] in_regA,
  input  logic [REG_AW-1:0] in_regB,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [OFF_W-1:0]  in_offset,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_valA,
  input  logic [DATA_W-1:0] in_valB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_reg,
  output logic [DATA_W-1:0] wb_value,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              br_taken,
  output logic [PC_W-1:0]   br_target,
  output logic              halted,
  output logic [31:0]       instr_count
`ifdef LC2K_EXEC_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_JALR = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  typedef enum logic [1:0] {IDLE, FULL, HALTED} state_t;

  typedef struct packed {
    logic              wb_en;
    logic [REG_AW-1:0] wb_reg;
    logic [DATA_W-1:0] wb_value;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              br_taken;
    logic [PC_W-1:0]   br_target;
    logic              is_halt;
`ifdef LC2K_EXEC_OVF_EN
    logic              ovf;
`endif
  } res_t;

  state_t state_q, state_d;
  res_t   res_q, res_d;
  logic [31:0] cnt_q;

  logic acc, retire;

  // regA index only matters to upstream hazard detection; the value arrives
  // already read on in_valA.
  logic unused_ok;
  assign unused_ok = ^in_regA;

  // ---------------------------------------------------------------- datapath
  logic [DATA_W-1:0] off_sx, addr, sum;
  logic [PC_W-1:0]   pc_inc;

  assign off_sx = {{(DATA_W-OFF_W){in_offset[OFF_W-1]}}, in_offset};
  assign addr   = in_valA + off_sx;
  assign sum    = in_valA + in_valB;
  assign pc_inc = in_pc + PC_ONE;

  always_comb begin
    res_d = '0;
    case (in_opcode)
      OP_ADD: begin
        res_d.wb_en    = 1'b1;
        res_d.wb_reg   = in_dest;
        res_d.wb_value = sum;
`ifdef LC2K_EXEC_OVF_EN
        res_d.ovf = (in_valA[DATA_W-1] == in_valB[DATA_W-1]) &&
                    (sum[DATA_W-1] != in_valA[DATA_W-1]);
`endif
      end
      OP_NOR: begin
        res_d.wb_en    = 1'b1;
        res_d.wb_reg   = in_dest;
        res_d.wb_value = ~(in_valA | in_valB);
      end
      OP_LW: begin
        res_d.mem_rd   = 1'b1;
        res_d.mem_addr = addr;
        res_d.wb_en    = 1'b1;
        res_d.wb_reg   = in_regB;
        res_d.wb_value = addr;  // memory stage substitutes load data
`ifdef LC2K_EXEC_OVF_EN
        res_d.ovf = (in_valA[DATA_W-1] == off_sx[DATA_W-1]) &&
                    (addr[DATA_W-1] != in_valA[DATA_W-1]);
`endif
      end
      OP_SW: begin
        res_d.mem_wr    = 1'b1;
        res_d.mem_addr  = addr;
        res_d.mem_wdata = in_valB;
`ifdef LC2K_EXEC_OVF_EN
        res_d.ovf = (in_valA[DATA_W-1] == off_sx[DATA_W-1]) &&
                    (addr[DATA_W-1] != in_valA[DATA_W-1]);
`endif
      end
      OP_BEQ: begin
        res_d.br_taken  = (in_valA == in_valB);
        res_d.br_target = pc_inc + off_sx[PC_W-1:0];
      end
      OP_JALR: begin
        // Target comes from the operand sampled now, so regA==regB still
        // jumps to the old value even though the same register is rewritten.
        res_d.wb_en     = 1'b1;
        res_d.wb_reg    = in_regB;
        res_d.wb_value  = {{(DATA_W-PC_W){1'b0}}, pc_inc};
        res_d.br_taken  = 1'b1;
        res_d.br_target = in_valA[PC_W-1:0];
      end
      OP_HALT: res_d.is_halt = 1'b1;
      default: ;  // noop: nothing enabled, still retires
    endcase
  end

  // --------------------------------------------------------------- control
  assign out_valid = (state_q == FULL);
  // Held low during reset so nothing is accepted while rst_n is asserted.
  assign in_ready  = rst_n && ((state_q == IDLE) || (state_q == FULL && out_ready));
  assign acc       = in_valid && in_ready;
  assign retire    = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (acc) state_d = FULL;
      FULL: begin
        if (retire) begin
          if (res_q.is_halt) state_d = HALTED;
          else if (!acc)     state_d = IDLE;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + 32'd1;
      // Anything handed over alongside a retiring halt is dropped: execution
      // has ended, and the result register is cleared for the halted state.
      if (retire && res_q.is_halt) res_q <= '0;
      else if (acc)                res_q <= res_d;
      else if (retire)             res_q <= '0;
    end
  end

  // --------------------------------------------------------------- outputs
  assign wb_en       = res_q.wb_en;
  assign wb_reg      = res_q.wb_reg;
  assign wb_value    = res_q.wb_value;
  assign mem_rd      = res_q.mem_rd;
  assign mem_wr      = res_q.mem_wr;
  assign mem_addr    = res_q.mem_addr;
  assign mem_wdata   = res_q.mem_wdata;
  assign br_taken    = res_q.br_taken;
  assign br_target   = res_q.br_target;
  assign halted      = (state_q == HALTED);
  assign instr_count = cnt_q;
`ifdef LC2K_EXEC_OVF_EN
  assign ovf         = res_q.ovf;
`endif

endmodule

// File: doc/lc2k_exec_stage.md
Name: lc2k_exec_stage

Overview:
- Execute stage sitting directly downstream of the LC2K register file.
- Consumes the two read operands (regA value, regB value) plus decoded instruction fields.
- Computes the ALU result, memory address, and branch decision. Produces a registered write-back request (dest reg, value, enable) that feeds the register file's write port and its ALU-done strobe.
- Single pipeline register with valid/ready handshake; halts permanently on a halt opcode.

Parameters:
- DATA_W, 32, operand/result width.
- REG_AW, 3, register-index width (8 registers).
- OFF_W, 16, offsetField width; sign-extended to DATA_W.
- PC_W, 16, program counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage can accept instruction this cycle.
- in_opcode  in  3  LC2K opcode: add=0 nor=1 lw=2 sw=3 beq=4 jalr=5 halt=6 noop=7.
- in_regA  in  REG_AW  regA index.
- in_regB  in  REG_AW  regB index.
- in_dest  in  REG_AW  destReg index (add/nor).
- in_offset  in  OFF_W  offsetField, two's complement.
- in_pc  in  PC_W  PC of instruction.
- in_valA  in  DATA_W  value of regA from register file.
- in_valB  in  DATA_W  value of regB from register file.
- out_valid  out  1  result register holds a completed instruction.
- out_ready  in  1  downstream accepts result.
- wb_en  out  1  register write requested (add, nor, lw, jalr).
- wb_reg  out  REG_AW  register to write.
- wb_value  out  DATA_W  ALU result / PC+1 for jalr; address for lw.
- mem_rd  out  1  lw access.
- mem_wr  out  1  sw access.
- mem_addr  out  DATA_W  valA + sext(offset).
- mem_wdata  out  DATA_W  valB for sw.
- br_taken  out  1  redirect PC.
- br_target  out  PC_W  new PC.
- halted  out  1  halt retired.
- instr_count  out  32  instructions retired (accepted by out handshake).

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, instr_count 0. in_ready is 0 while in reset.
- States:
  - IDLE: result register empty.
  - FULL: result register loaded.
  - HALTED: terminal.
- Accept when in_valid && in_ready.
- in_ready = (state==IDLE) || (state==FULL && out_ready). It is 0 in HALTED.
- Latency: exactly 1 cycle from accept to out_valid=1. Back-to-back throughput is 1/cycle when out_ready is held 1.
- out_valid=1 in FULL. Outputs are stable until out_ready sampled 1.
- Retire (out_valid && out_ready):
  - instr_count += 1, wrapping at 2^32.
  - If no simultaneous accept, go to IDLE; a simultaneous accept stays in FULL with new contents.
- Per-opcode results:
  - add: wb_value = valA+valB, mod 2^DATA_W; wb_reg = in_dest.
  - nor: wb_value = ~(valA|valB); wb_reg = in_dest.
  - lw: mem_rd=1, mem_addr = valA + sext(offset), wb_reg = in_regB, wb_en=1. wb_value = mem_addr; the memory stage replaces it.
  - sw: mem_wr=1, mem_addr as lw, mem_wdata=valB, wb_en=0.
  - beq: br_taken = (valA==valB), br_target = pc+1+sext(offset), truncated to PC_W.
  - jalr: wb_reg=in_regB, wb_value=pc+1 (zero-extended), br_taken=1, br_target=valA[PC_W-1:0].
    - If regA==regB, the target still uses the pre-write valA.
  - noop: all enables 0; still retires and counts.
  - halt: retires with halted=0 in the FULL cycle. On retire, move to HALTED, set halted=1, clear out_valid, and drop in_ready. Only reset leaves HALTED.
- Enables for unused functions are forced 0: wb_en, mem_rd, mem_wr, br_taken.
- Hazard rule: operands are sampled at accept. A write-back to the same register retiring in the same cycle is not forwarded; upstream must stall. Operand values are never captured combinationally after accept.
- Reset mid-operation: contents are discarded, no retire is counted, and the stage returns to IDLE.

Optional Feature:
- Macro: LC2K_EXEC_OVF_EN.
- With the macro: extra output port ovf (1 bit), registered with the result and reset to 0.
  - Asserted for add when signed overflow occurs (operand signs equal, result sign differs).
  - Also asserted for lw/sw when the address computation overflows signed.
  - 0 for other opcodes.
- Without the macro: no ovf port and no overflow logic; all other behaviour is identical.

Test Plan:
- Reset released, add valA=5 valB=7 dest=3 accepted at cycle 0 -> cycle 1 out_valid=1, wb_en=1, wb_reg=3, wb_value=12; instr_count=1 after retire.
- nor valA=0x0000FFFF valB=0x00FF0000 -> wb_value=0xFF000000. lw valA=10, offset=0xFFFF -> mem_rd=1, mem_addr=9, wb_reg=regB.
- beq pc=20, valA=valB=4, offset=-3 -> br_taken=1, br_target=18. Same with valA≠valB -> br_taken=0.
- out_ready held 0 for 3 cycles with a second instruction pending -> in_ready=0, outputs stable. Then out_ready=1 -> retire and accept in the same cycle, with out_valid continuous.
- halt accepted then retired -> halted=1, in_ready=0 forever. Further in_valid is ignored and instr_count is frozen. rst_n pulse -> all zero, IDLE.
- LC2K_EXEC_OVF_EN defined: add 0x7FFFFFFF+1 -> wb_value=0x80000000, ovf=1. With 1+1, ovf=0.
